// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Latency 34 cycles start->done for every op; stall_req holds ID off, start is only taken in IDLE.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mt_hi_we,
    input  logic            mt_lo_we,
    input  logic [XLEN-1:0] mt_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall_req
);

    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   orig_a;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] step_mul;
    logic [2*XLEN-1:0] step_div;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & src_a[XLEN-1];
        b_neg     = signed_op & src_b[XLEN-1];
        abs_a     = a_neg ? -src_a : src_a;
        abs_b     = b_neg ? -src_b : src_b;
    end

    // Multiply: the multiplier sits in acc's low half and shifts out as the product shifts in.
    // Divide: the dividend shifts out of the low half while quotient bits shift in behind it.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        step_mul = {add_sum, acc[XLEN-1:1]};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        trial    = rem_sh - {1'b0, opb};
        step_div = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            orig_a   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= {{XLEN{1'b0}}, abs_a};
                        opb      <= abs_b;
                        orig_a   <= src_a;
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (src_b == '0);
                        count    <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= is_div ? step_div : step_mul;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*XLEN-1:XLEN];
                        lo <= prod_fix[XLEN-1:0];
                    end else if (div_zero) begin
                        hi <= orig_a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // MT writes land in IDLE or DONE; in DONE they overwrite the fresh result.
            if (state == S_IDLE || state == S_DONE) begin
                if (mt_hi_we) begin
                    hi <= mt_data;
                end
                if (mt_lo_we) begin
                    lo <= mt_data;
                end
            end
        end
    end

    assign busy      = (state == S_RUN) || (state == S_FIX);
    assign done      = (state == S_DONE);
    assign stall_req = busy;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit against a transaction-level HI/LO model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mt_hi_we = 1'b0;
    logic        mt_lo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Architectural result of an op, straight from integer arithmetic; returns {hi, lo}.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o == 2'd0) begin
            ref_res = sa * sb;
        end else if (o == 2'd1) begin
            ref_res = ua * ub;
        end else if (b == 32'd0) begin
            ref_res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
            ref_res = {r[31:0], q[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            ref_res = {ur[31:0], uq[31:0]};
        end
    endfunction

    // Model: an accepted op produces its result exactly 33 edges later.
    int          edge_n = 0;
    int          land = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        logic was_done;
        edge_n++;
        was_done = m_done;
        m_done = 1'b0;
        if (rst) begin
            m_hi = '0;
            m_lo = '0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (edge_n == land) begin
                {m_hi, m_lo} = m_res;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (mt_hi_we) m_hi = mt_data;
            if (mt_lo_we) m_lo = mt_data;
            if (start && !was_done) begin
                m_res = ref_res(op, src_a, src_b);
                land = edge_n + 33;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("hi", {32'b0, hi}, {32'b0, m_hi});
            chk("lo", {32'b0, lo}, {32'b0, m_lo});
            chk("busy", {63'b0, busy}, {63'b0, m_busy});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("stall_req", {63'b0, stall_req}, {63'b0, m_busy});
        end
    end

    // Launches one op at the next negedge and waits for done; optionally pokes a start and
    // an MTHI into the busy window at cycle 5. Returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0; mt_hi_we = 1'b0;
            src_a = $urandom; src_b = $urandom;
            if (intrude && k == 5) begin
                start = 1'b1; op = 2'd1; src_a = 32'd9; src_b = 32'd9;
                mt_hi_we = 1'b1; mt_data = 32'hDEAD_BEEF;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'h0000_0000;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = $urandom_range(0, 15);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        int lat, bc, seen;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        rst = 1'b0;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("latency", lat, 64'd34);
        chk("busy_cycles", bc, 64'd33);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bc);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd3, 32'd7, 32'd0, 1'b0, lat, bc);
        chk("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        chk("divz_latency", lat, 64'd34);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(2'd1, 32'd3, 32'd5, 1'b1, lat, bc);
        chk("busy_ignore", {hi, lo}, 64'h0000_0000_0000_000F);
        chk("busy_ignore_lat", lat, 64'd34);

        // In the DONE cycle: MTHI lands, start is dropped.
        mt_hi_we = 1'b1; mt_data = 32'hCAFE_BABE;
        start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        mt_hi_we = 1'b0; start = 1'b0;
        chk("mthi_done", {hi, lo}, 64'hCAFE_BABE_0000_000F);
        chk("start_in_done", {63'b0, busy}, 64'd0);
        mt_lo_we = 1'b1; mt_data = 32'h1234_5678;
        @(negedge clk);
        mt_lo_we = 1'b0;
        chk("mtlo_idle", {32'b0, lo}, 64'h1234_5678);

        @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 32'd100; src_b = 32'd100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 64'd0);
        run_op(2'd0, 32'd6, 32'hFFFF_FFFE, 1'b0, lat, bc);
        chk("after_abort", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("after_abort_lat", lat, 64'd34);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 599) == 0);
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom_range(0, 3));
            src_a    = pick();
            src_b    = pick();
            mt_hi_we = ($urandom_range(0, 7) == 0);
            mt_lo_we = ($urandom_range(0, 7) == 0);
            mt_data  = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
